// File: rtl/core_pkg.sv
// Shared definitions for the combined ARM/RISC-V core: datapath widths,
// the decode->execute bundle and the hard-wired register test.
package core_pkg;

   localparam int XLEN   = 32;  // datapath width (fixed)
   localparam int CTRL_W = 16;  // opaque execute-control bundle width

   // Everything the E stage captures from D, in one record.
   typedef struct packed {
      logic              valid;
      logic              arm;
      logic [4:0]        ra1;
      logic [4:0]        ra2;
      logic [4:0]        wa3;
      logic              reg_write;
      logic              mem_to_reg;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [CTRL_W-1:0] ctrl;
   } de_bundle_t;

   // Registers whose read value never comes from the regfile array:
   // RISC-V x0 (always zero) and ARM r15 (the PC, substituted in D).
   // ARM compares only the low nibble, so address 31 is also excluded.
   function automatic logic reg_excluded(input logic arm, input logic [4:0] addr);
      return arm ? (addr[3:0] == 4'hF) : (addr == 5'd0);
   endfunction

endpackage

// File: rtl/idex_stage_if.sv
// Decode->execute stage bus: D-stage inputs, writeback port,
// execute back-pressure/flush and the registered E-stage outputs.
interface idex_stage_if;
   import core_pkg::*;

   // D stage
   logic              armD, validD;
   logic [4:0]        ra1D, ra2D, wa3D;
   logic              use1D, use2D;
   logic [XLEN-1:0]   rd1D, rd2D, immD, pcD;
   logic              regWriteD, memToRegD;
   logic [CTRL_W-1:0] ctrlD;
   // writeback port (same as regfile write port)
   logic              regWriteW;
   logic [4:0]        wa3W;
   logic [XLEN-1:0]   resultW;
   // pipeline control
   logic              stallE, flushE, stallD;
   // E stage
   logic              validE, armE, regWriteE, memToRegE;
   logic [4:0]        ra1E, ra2E, wa3E;
   logic [XLEN-1:0]   rd1E, rd2E, immE, pcE;
   logic [CTRL_W-1:0] ctrlE;

   // Pipeline control/decode side: drives D/W/control, observes E.
   modport master (
      output armD, validD, ra1D, ra2D, wa3D, use1D, use2D, rd1D, rd2D, immD, pcD,
             regWriteD, memToRegD, ctrlD, regWriteW, wa3W, resultW, stallE, flushE,
      input  stallD, validE, armE, regWriteE, memToRegE, ra1E, ra2E, wa3E,
             rd1E, rd2E, immE, pcE, ctrlE
   );

   // The stage itself.
   modport slave (
      input  armD, validD, ra1D, ra2D, wa3D, use1D, use2D, rd1D, rd2D, immD, pcD,
             regWriteD, memToRegD, ctrlD, regWriteW, wa3W, resultW, stallE, flushE,
      output stallD, validE, armE, regWriteE, memToRegE, ra1E, ra2E, wa3E,
             rd1E, rd2E, immE, pcE, ctrlE
   );

endinterface

// File: rtl/idex_stage_bypass.sv
// Same-cycle writeback bypass for one regfile read port. The regfile writes
// at the clock edge, so a D read in the W write cycle returns the old value;
// substitute the W result when W targets this read address.
module fwd_wb_bypass
   import core_pkg::*;
(
   input  logic            arm,
   input  logic [4:0]      ra,
   input  logic [XLEN-1:0] rd,
   input  logic            reg_write_w,
   input  logic [4:0]      wa3_w,
   input  logic [XLEN-1:0] result_w,
   output logic [XLEN-1:0] fwd
);

   logic hit;

   // Full 5-bit match in both modes; x0 / ARM r15 are never bypassed.
   assign hit = reg_write_w && (wa3_w == ra) && !reg_excluded(arm, ra);
   assign fwd = hit ? result_w : rd;

endmodule

// File: rtl/idex_stage.sv
// Decode->execute pipeline register with writeback bypass, load-use bubble
// insertion and stall/flush priority.
module idex_stage
   import core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   idex_stage_if.slave bus
);

   logic [XLEN-1:0] fwd1, fwd2;
   logic            use_hit1, use_hit2, lu;
   de_bundle_t      d_bundle, e_q;

   fwd_wb_bypass u_byp1 (
      .arm(bus.armD), .ra(bus.ra1D), .rd(bus.rd1D),
      .reg_write_w(bus.regWriteW), .wa3_w(bus.wa3W), .result_w(bus.resultW),
      .fwd(fwd1)
   );

   fwd_wb_bypass u_byp2 (
      .arm(bus.armD), .ra(bus.ra2D), .rd(bus.rd2D),
      .reg_write_w(bus.regWriteW), .wa3_w(bus.wa3W), .result_w(bus.resultW),
      .fwd(fwd2)
   );

   // Load in E whose destination a valid D instruction actually reads.
   assign use_hit1 = bus.use1D && (bus.ra1D == e_q.wa3) && !reg_excluded(bus.armD, bus.ra1D);
   assign use_hit2 = bus.use2D && (bus.ra2D == e_q.wa3) && !reg_excluded(bus.armD, bus.ra2D);
   assign lu       = e_q.valid && e_q.mem_to_reg && e_q.reg_write && bus.validD &&
                     (use_hit1 || use_hit2);

   assign bus.stallD = lu || bus.stallE;

   // Assemble the D record; write/load flags are masked for invalid slots.
   always_comb begin
      // NOTE: default the whole record first so no path leaves a field unassigned (no latch).
      d_bundle            = '0;
      d_bundle.valid      = bus.validD;
      d_bundle.arm        = bus.armD;
      d_bundle.ra1        = bus.ra1D;
      d_bundle.ra2        = bus.ra2D;
      d_bundle.wa3        = bus.wa3D;
      d_bundle.reg_write  = bus.regWriteD && bus.validD;
      d_bundle.mem_to_reg = bus.memToRegD && bus.validD;
      d_bundle.rd1        = fwd1;
      d_bundle.rd2        = fwd2;
      d_bundle.imm        = bus.immD;
      d_bundle.pc         = bus.pcD;
      d_bundle.ctrl       = bus.ctrlD;
   end

   // E register: stall holds, flush or load-use inserts a cleared bubble.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // this is a flop register, not a memory, so clearing it on reset is cheap.
      if (reset)
         e_q <= '0;
      else if (bus.stallE)
         e_q <= e_q;
      else if (bus.flushE || lu)
         e_q <= '0;
      else
         e_q <= d_bundle;
   end

   assign bus.validE    = e_q.valid;
   assign bus.armE      = e_q.arm;
   assign bus.regWriteE = e_q.reg_write;
   assign bus.memToRegE = e_q.mem_to_reg;
   assign bus.ra1E      = e_q.ra1;
   assign bus.ra2E      = e_q.ra2;
   assign bus.wa3E      = e_q.wa3;
   assign bus.rd1E      = e_q.rd1;
   assign bus.rd2E      = e_q.rd2;
   assign bus.immE      = e_q.imm;
   assign bus.pcE       = e_q.pc;
   assign bus.ctrlE     = e_q.ctrl;

endmodule
